// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: bundle between the issue/CDB/consumer side and the reorder buffer
// Signals:
//   flush, dispatch_valid, dispatch_rd       allocation and discard requests
//   dispatch_tag, full, empty                allocation status
//   cdb_valid, cdb_tag, cdb_data             result broadcast
//   commit_valid/we/rd/data/tag              registered retirement toward the register file
//   q1/q2_tag -> q1/q2_ready, q1/q2_data     operand lookup
// Modports: master = core side driving requests, slave = reorder buffer.
interface reorder_buffer_if #(
  parameter int ROB_S_BIT      = 3,
  parameter int REG_CARD_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
);
  logic                      flush;
  logic                      dispatch_valid;
  logic [REG_CARD_WIDTH-1:0] dispatch_rd;
  logic [ROB_S_BIT-1:0]      dispatch_tag;
  logic                      full;
  logic                      empty;
  logic                      cdb_valid;
  logic [ROB_S_BIT-1:0]      cdb_tag;
  logic [DATA_WIDTH-1:0]     cdb_data;
  logic                      commit_valid;
  logic                      commit_we;
  logic [REG_CARD_WIDTH-1:0] commit_rd;
  logic [DATA_WIDTH-1:0]     commit_data;
  logic [ROB_S_BIT-1:0]      commit_tag;
  logic [ROB_S_BIT-1:0]      q1_tag, q2_tag;
  logic                      q1_ready, q2_ready;
  logic [DATA_WIDTH-1:0]     q1_data, q2_data;
  modport master (
    output flush, dispatch_valid, dispatch_rd, cdb_valid, cdb_tag, cdb_data, q1_tag, q2_tag,
    input  dispatch_tag, full, empty, commit_valid, commit_we, commit_rd, commit_data, commit_tag,
           q1_ready, q2_ready, q1_data, q2_data
  );
  modport slave (
    input  flush, dispatch_valid, dispatch_rd, cdb_valid, cdb_tag, cdb_data, q1_tag, q2_tag,
    output dispatch_tag, full, empty, commit_valid, commit_we, commit_rd, commit_data, commit_tag,
           q1_ready, q2_ready, q1_data, q2_data
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order-retire buffer collecting CDB results ahead of the register file
// Ports:
//   clk   clock, all state updates on posedge
//   rst   asynchronous active-low reset
//   rob   reorder_buffer_if.slave: dispatch, CDB writeback, commit outputs, operand lookup
// Optional feature: define ROB_FORWARD_EN to enable operand lookup with combinational CDB
// bypass; otherwise q1/q2 ready/data are tied to zero.
module reorder_buffer #(
  parameter int ROB_S_BIT      = 3,
  parameter int REG_CARD_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave rob
);
  localparam int N = 1 << ROB_S_BIT;
  logic [N-1:0]              valid_q, valid_d, ready_q, ready_d;
  logic [REG_CARD_WIDTH-1:0] rd_q [N];
  logic [REG_CARD_WIDTH-1:0] rd_d [N];
  logic [DATA_WIDTH-1:0]     data_q [N];
  logic [DATA_WIDTH-1:0]     data_d [N];
  logic [ROB_S_BIT-1:0]      head_q, head_d, tail_q, tail_d;
  logic [ROB_S_BIT:0]        count_q, count_d;
  logic                      cv_q, cv_d, cwe_q, cwe_d;
  logic [REG_CARD_WIDTH-1:0] crd_q, crd_d;
  logic [DATA_WIDTH-1:0]     cdata_q, cdata_d;
  logic [ROB_S_BIT-1:0]      ctag_q, ctag_d;
  logic                      acc_disp, acc_commit;
  // count never exceeds N, so its MSB alone marks a full buffer
  assign rob.full         = count_q[ROB_S_BIT];
  assign rob.empty        = count_q == '0;
  assign rob.dispatch_tag = tail_q;
  assign acc_disp   = rob.dispatch_valid && !rob.full && !rob.flush;
  assign acc_commit = valid_q[head_q] && ready_q[head_q] && !rob.flush;
  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (ROB_S_BIT+1)'(acc_disp) - (ROB_S_BIT+1)'(acc_commit);
    cv_d    = acc_commit;
    cwe_d   = acc_commit && rd_q[head_q] != '0;
    crd_d   = acc_commit ? rd_q[head_q] : crd_q;
    cdata_d = acc_commit ? data_q[head_q] : cdata_q;
    ctag_d  = acc_commit ? head_q : ctag_q;
    if (rob.cdb_valid && valid_q[rob.cdb_tag]) begin
      data_d[rob.cdb_tag]  = rob.cdb_data;
      ready_d[rob.cdb_tag] = 1'b1;
    end
    if (acc_commit) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    // tail entry is never valid when dispatch is accepted, so a CDB hit cannot collide with it
    if (acc_disp) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = 1'b0;
      rd_d[tail_q]    = rob.dispatch_rd;
      tail_d          = tail_q + 1'b1;
    end
    if (rob.flush) begin
      valid_d = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      cv_d    = 1'b0;
      cwe_d   = 1'b0;
      crd_d   = '0;
      cdata_d = '0;
      ctag_d  = '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      ready_q <= '0;
      rd_q    <= '{default: '0};
      data_q  <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cv_q    <= 1'b0;
      cwe_q   <= 1'b0;
      crd_q   <= '0;
      cdata_q <= '0;
      ctag_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cv_q    <= cv_d;
      cwe_q   <= cwe_d;
      crd_q   <= crd_d;
      cdata_q <= cdata_d;
      ctag_q  <= ctag_d;
    end
  end
  assign rob.commit_valid = cv_q;
  assign rob.commit_we    = cwe_q;
  assign rob.commit_rd    = crd_q;
  assign rob.commit_data  = cdata_q;
  assign rob.commit_tag   = ctag_q;
`ifdef ROB_FORWARD_EN
  logic byp1, byp2;
  assign byp1         = rob.cdb_valid && rob.cdb_tag == rob.q1_tag;
  assign byp2         = rob.cdb_valid && rob.cdb_tag == rob.q2_tag;
  assign rob.q1_ready = byp1 || (valid_q[rob.q1_tag] && ready_q[rob.q1_tag]);
  assign rob.q2_ready = byp2 || (valid_q[rob.q2_tag] && ready_q[rob.q2_tag]);
  assign rob.q1_data  = byp1 ? rob.cdb_data : data_q[rob.q1_tag];
  assign rob.q2_data  = byp2 ? rob.cdb_data : data_q[rob.q2_tag];
`else
  assign rob.q1_ready = 1'b0;
  assign rob.q2_ready = 1'b0;
  assign rob.q1_data  = '0;
  assign rob.q2_data  = '0;
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and randomized checks of reorder_buffer against a queue model
module tb_reorder_buffer;
  localparam int SB = 3, RW = 5, DW = 32, N = 8;
`ifdef ROB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  reorder_buffer_if #(.ROB_S_BIT(SB), .REG_CARD_WIDTH(RW), .DATA_WIDTH(DW)) bus ();
  reorder_buffer #(.ROB_S_BIT(SB), .REG_CARD_WIDTH(RW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .rob(bus)
  );
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [SB-1:0] tag;
    logic [RW-1:0] rd;
    bit            rdy;
    logic [DW-1:0] data;
  } ent_t;
  // program-ordered list of live entries; front is the oldest
  ent_t          m_q[$];
  int            m_tail;
  bit            m_full;
  bit            e_cv, e_we;
  logic [RW-1:0] e_rd;
  logic [DW-1:0] e_data;
  logic [SB-1:0] e_tag;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  function automatic void look(input logic [SB-1:0] t, output bit r, output logic [DW-1:0] d);
    r = 1'b0;
    d = '0;
    if (FWD) begin
      foreach (m_q[i]) if (m_q[i].tag == t && m_q[i].rdy) begin r = 1'b1; d = m_q[i].data; end
      if (bus.cdb_valid && bus.cdb_tag == t) begin r = 1'b1; d = bus.cdb_data; end
    end
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst || bus.flush) begin
      m_q.delete();
      m_tail = 0;
      e_cv = 1'b0;
      e_we = 1'b0;
    end else begin
      m_full = m_q.size() == N;
      e_cv = 1'b0;
      e_we = 1'b0;
      if (m_q.size() > 0 && m_q[0].rdy) begin
        e_cv   = 1'b1;
        e_we   = m_q[0].rd != 0;
        e_rd   = m_q[0].rd;
        e_data = m_q[0].data;
        e_tag  = m_q[0].tag;
        void'(m_q.pop_front());
      end
      if (bus.cdb_valid)
        foreach (m_q[i]) if (m_q[i].tag == bus.cdb_tag) begin m_q[i].rdy = 1'b1; m_q[i].data = bus.cdb_data; end
      if (bus.dispatch_valid && !m_full) begin
        m_q.push_back('{tag: m_tail[SB-1:0], rd: bus.dispatch_rd, rdy: 1'b0, data: '0});
        m_tail = (m_tail + 1) % N;
      end
    end
  end
  always @(negedge clk) begin
    bit            r1, r2;
    logic [DW-1:0] d1, d2;
    chk("commit_valid", bus.commit_valid, e_cv);
    chk("commit_we", bus.commit_we, e_we);
    if (e_cv) begin
      chk("commit_rd", bus.commit_rd, e_rd);
      chk("commit_data", bus.commit_data, e_data);
      chk("commit_tag", bus.commit_tag, e_tag);
    end
    chk("full", bus.full, m_q.size() == N);
    chk("empty", bus.empty, m_q.size() == 0);
    chk("dispatch_tag", bus.dispatch_tag, m_tail);
    look(bus.q1_tag, r1, d1);
    look(bus.q2_tag, r2, d2);
    chk("q1_ready", bus.q1_ready, r1);
    chk("q2_ready", bus.q2_ready, r2);
    if (r1 || !FWD) chk("q1_data", bus.q1_data, d1);
    if (r2 || !FWD) chk("q2_data", bus.q2_data, d2);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input bit f, input bit dv, input logic [RW-1:0] rd, input bit cv,
                     input logic [SB-1:0] ct, input logic [DW-1:0] cd);
    bus.flush = f;
    bus.dispatch_valid = dv;
    bus.dispatch_rd = rd;
    bus.cdb_valid = cv;
    bus.cdb_tag = ct;
    bus.cdb_data = cd;
  endtask
  initial begin
    drv(0, 0, 0, 0, 0, 0);
    bus.q1_tag = '0;
    bus.q2_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_commit_valid", bus.commit_valid, 0);
    chk("rst_commit_data", bus.commit_data, 0);
    chk("rst_commit_rd", bus.commit_rd, 0);
    for (int i = 0; i < N; i++) begin
      drv(0, 1, RW'(i + 1), 0, 0, 0);
      chk("fill_tag", bus.dispatch_tag, i);
      tick();
    end
    chk("fill_full", bus.full, 1);
    drv(0, 1, 9, 0, 0, 0);
    tick();
    chk("ninth_tail", bus.dispatch_tag, 0);
    chk("ninth_full", bus.full, 1);
    drv(0, 0, 0, 1, 0, 32'hA5);
    tick();
    drv(0, 1, 9, 0, 0, 0);
    tick();
    chk("fullret_valid", bus.commit_valid, 1);
    chk("fullret_tag", bus.commit_tag, 0);
    chk("fullret_data", bus.commit_data, 32'hA5);
    chk("fullret_full", bus.full, 0);
    chk("fullret_tail", bus.dispatch_tag, 0);
    drv(0, 1, 10, 0, 0, 0);
    chk("wrap_tag", bus.dispatch_tag, 0);
    tick();
    chk("wrap_full", bus.full, 1);
    drv(1, 0, 0, 0, 0, 0);
    tick();
    chk("flush1_empty", bus.empty, 1);
    for (int i = 0; i < 5; i++) begin
      drv(0, 1, RW'(i + 2), 0, 0, 0);
      tick();
    end
    drv(1, 1, 7, 1, 1, 32'h1234);
    tick();
    chk("flush_empty", bus.empty, 1);
    chk("flush_commit_valid", bus.commit_valid, 0);
    chk("flush_tag", bus.dispatch_tag, 0);
    drv(0, 1, 3, 0, 0, 0);
    tick();
    drv(0, 0, 0, 1, 0, 32'hDEADBEEF);
    tick();
    chk("lat_early", bus.commit_valid, 0);
    drv(0, 0, 0, 0, 0, 0);
    tick();
    chk("lat_valid", bus.commit_valid, 1);
    chk("lat_we", bus.commit_we, 1);
    chk("lat_rd", bus.commit_rd, 3);
    chk("lat_data", bus.commit_data, 32'hDEADBEEF);
    chk("lat_tag", bus.commit_tag, 0);
    tick();
    chk("lat_pulse", bus.commit_valid, 0);
    drv(1, 0, 0, 0, 0, 0);
    tick();
    drv(0, 1, 4, 0, 0, 0);
    tick();
    drv(0, 1, 5, 0, 0, 0);
    tick();
    drv(0, 0, 0, 1, 1, 32'h11);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 1, 0, 32'h10);
    tick();
    chk("ooo_wait", bus.commit_valid, 0);
    drv(0, 0, 0, 0, 0, 0);
    tick();
    chk("ooo_first_tag", bus.commit_tag, 0);
    chk("ooo_first_data", bus.commit_data, 32'h10);
    tick();
    chk("ooo_second_valid", bus.commit_valid, 1);
    chk("ooo_second_tag", bus.commit_tag, 1);
    chk("ooo_second_data", bus.commit_data, 32'h11);
    drv(0, 1, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 1, 2, 32'h77);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    tick();
    chk("r0_valid", bus.commit_valid, 1);
    chk("r0_we", bus.commit_we, 0);
    chk("r0_tag", bus.commit_tag, 2);
    drv(1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, RW'(i + 1), 0, 0, 0);
      tick();
    end
    bus.q1_tag = 2;
    drv(0, 0, 0, 1, 2, 32'h55);
    #1;
    chk("fwd_ready", bus.q1_ready, FWD);
    chk("fwd_data", bus.q1_data, FWD ? 32'h55 : 32'h0);
    tick();
    drv(0, 0, 0, 1, 0, 32'h66);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    tick();
    chk("pre_rst_valid", bus.commit_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_empty", bus.empty, 1);
    chk("async_rst_valid", bus.commit_valid, 0);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [SB-1:0] ct;
      ct = SB'($urandom_range(0, N - 1));
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0) ct = m_q[$urandom_range(0, m_q.size() - 1)].tag;
      drv($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, RW'($urandom_range(0, 3)),
          $urandom_range(0, 9) < 7, ct, $urandom);
      bus.q1_tag = SB'($urandom_range(0, N - 1));
      bus.q2_tag = ct;
      tick();
    end
    drv(0, 0, 0, 0, 0, 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
